// File: rtl/predict_update_ctrl_pkg.sv
// predict_update_ctrl_pkg: control-bit encoding, saturating counter helpers and sequencer states
package predict_update_ctrl_pkg;
  localparam logic [1:0] CB_SNT = 2'b00;
  localparam logic [1:0] CB_WNT = 2'b01;
  localparam logic [1:0] CB_WT  = 2'b10;
  localparam logic [1:0] CB_ST  = 2'b11;
  localparam int ENTRY_W = 66;
  typedef enum logic [1:0] {RESET, FLUSH, RUN} state_e;
  function automatic logic [1:0] sat_inc(input logic [1:0] cb);
    return (cb == CB_ST) ? CB_ST : cb + 2'd1;
  endfunction
  function automatic logic [1:0] sat_dec(input logic [1:0] cb);
    return (cb == CB_SNT) ? CB_SNT : cb - 2'd1;
  endfunction
endpackage

// File: rtl/predict_update_ctrl_fifo.sv
// pred_upd_fifo: synchronous update queue; pointers carry an extra wrap bit to tell full from empty
module pred_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop_i) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= din_i;
  end
  assign dout_o  = mem_q[rptr_q[AW-1:0]];
  assign empty_o = wptr_q == rptr_q;
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
endmodule

// File: rtl/predict_update_ctrl.sv
// predict_update_ctrl: branch-resolution write sequencer for the prediction cache,
// arbitrating its single write port between the line flush sweep and queued updates.
module predict_update_ctrl
  import predict_update_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_LINES  = 128,
  parameter int IDX_BITS   = 7
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Res_Valid,
  output logic        Res_Ready,
  input  logic [31:0] Res_PC,
  input  logic [31:0] Res_Target,
  input  logic        Res_Taken,
  input  logic        Res_Hit,
  input  logic [1:0]  Res_OldCB,
  input  logic        Flush_Req,
  output logic        Flush_Busy,
  output logic        WE,
  output logic [31:0] WAddr,
  output logic [31:0] Data,
  output logic [1:0]  Instr_new_CB
);
  state_e state_q, state_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic we_q, we_d;
  logic [31:0] waddr_q, waddr_d, data_q, data_d;
  logic [1:0] cb_q, cb_d, new_cb;
  logic [ENTRY_W-1:0] head, in_w;
  logic accept, needs_wr, cand, clr, push, pop, full, empty;
  assign Res_Ready  = (state_q != RESET) && !full;
  assign Flush_Busy = state_q == FLUSH;
  assign accept     = Res_Valid && Res_Ready;
  assign new_cb     = Res_Hit ? (Res_Taken ? sat_inc(Res_OldCB) : sat_dec(Res_OldCB)) : CB_WT;
  assign needs_wr   = Res_Taken || (Res_Hit && new_cb != Res_OldCB);
  assign cand       = accept && needs_wr && !Flush_Req;
  assign clr        = Flush_Req && (state_q != RESET);
  assign in_w       = {Res_PC, Res_Target, new_cb};
  pred_upd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk_i(Clk), .rst_ni(Rst), .clr_i(clr), .push_i(push), .pop_i(pop),
    .din_i(in_w), .dout_o(head), .full_o(full), .empty_o(empty)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    data_d  = data_q;
    cb_d    = cb_q;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      RESET: begin
        state_d = FLUSH;
        idx_d   = '0;
      end
      FLUSH: begin
        if (Flush_Req) idx_d = '0;
        else if (idx_q == IDX_BITS'(NUM_LINES - 1)) state_d = RUN;
        else idx_d = idx_q + IDX_BITS'(1);
      end
      RUN: begin
        if (Flush_Req) begin
          state_d = FLUSH;
          idx_d   = '0;
        end
      end
      default: state_d = RESET;
    endcase
    if (state_d == FLUSH) begin
      we_d    = 1'b1;
      waddr_d = 32'(idx_d);
      data_d  = '0;
      cb_d    = CB_SNT;
      push    = cand;
    end else begin
      // an empty queue lets a fresh resolution go straight to the write port
      pop  = !empty;
      push = cand && !empty;
      we_d = !empty || cand;
      {waddr_d, data_d, cb_d} = !empty ? head : (cand ? in_w : {waddr_q, data_q, cb_q});
    end
  end
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= RESET;
      idx_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      data_q  <= '0;
      cb_q    <= CB_SNT;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      cb_q    <= cb_d;
    end
  end
  assign WE           = we_q;
  assign WAddr        = waddr_q;
  assign Data         = data_q;
  assign Instr_new_CB = cb_q;
endmodule

// File: tb/tb_predict_update_ctrl.sv
// tb_predict_update_ctrl: directed scenarios plus randomized resolutions checked
// against a queue-based model of the prediction update and flush rules.
module tb_predict_update_ctrl;
  localparam int FIFO_DEPTH = 4;
  localparam int NUM_LINES  = 128;
  localparam int IDX_BITS   = 7;
  logic Clk = 1'b0, Rst = 1'b0;
  logic Res_Valid = 1'b0, Res_Taken = 1'b0, Res_Hit = 1'b0, Flush_Req = 1'b0;
  logic [31:0] Res_PC = '0, Res_Target = '0;
  logic [1:0] Res_OldCB = '0;
  logic Res_Ready, Flush_Busy, WE;
  logic [31:0] WAddr, Data;
  logic [1:0] Instr_new_CB;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] pc; logic [31:0] tgt; logic [1:0] cb;} wr_t;
  wr_t q[$];

  always #5 Clk = ~Clk;

  predict_update_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .NUM_LINES(NUM_LINES), .IDX_BITS(IDX_BITS)) dut (
    .Clk(Clk), .Rst(Rst), .Res_Valid(Res_Valid), .Res_Ready(Res_Ready), .Res_PC(Res_PC),
    .Res_Target(Res_Target), .Res_Taken(Res_Taken), .Res_Hit(Res_Hit), .Res_OldCB(Res_OldCB),
    .Flush_Req(Flush_Req), .Flush_Busy(Flush_Busy), .WE(WE), .WAddr(WAddr), .Data(Data),
    .Instr_new_CB(Instr_new_CB)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Prediction rule from the CB definition: 2-bit saturating counter, allocate weak-taken on a taken miss
  function automatic logic ref_update(input logic hit, input logic taken, input logic [1:0] old,
                                      output logic [1:0] cb);
    int o, n;
    o = int'(old);
    if (!hit) begin
      cb = 2'd2;
      return taken;
    end
    n = taken ? ((o == 3) ? 3 : o + 1) : ((o == 0) ? 0 : o - 1);
    cb = 2'(n);
    return taken || (n != o);
  endfunction

  task automatic flush_run(input int from, input int n);
    for (int i = from; i < from + n; i++) begin
      chk("flush_write", {Flush_Busy, WE, WAddr, Data, Instr_new_CB},
          {1'b1, 1'b1, 32'(i), 32'h0, 2'b00});
      tick();
    end
  endtask

  task automatic wait_flush_end;
    int n = 0;
    while (Flush_Busy && n < 300) begin
      tick();
      n++;
    end
    chk("flush_end_timeout", Flush_Busy, 1'b0);
  endtask

  task automatic resolve(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic taken, input logic hit, input logic [1:0] old,
                         input logic exp_we, input logic [1:0] exp_cb);
    Res_PC = pc; Res_Target = tgt; Res_Taken = taken; Res_Hit = hit; Res_OldCB = old;
    Res_Valid = 1'b1;
    tick();
    Res_Valid = 1'b0;
    chk(tag, WE, exp_we);
    if (exp_we) chk(tag, {WAddr, Data, Instr_new_CB}, {pc, tgt, exp_cb});
    tick();
  endtask

  task automatic push_miss(input logic [31:0] pc, input logic [31:0] tgt);
    Res_PC = pc; Res_Target = tgt; Res_Taken = 1'b1; Res_Hit = 1'b0; Res_OldCB = 2'b00;
    Res_Valid = 1'b1;
  endtask

  initial begin
    logic [1:0] cb;
    int idx;
    bit in_fl;
    wr_t w;
    tick(); tick();
    chk("reset_outs", {WE, WAddr, Data, Instr_new_CB, Res_Ready, Flush_Busy}, '0);
    Rst = 1'b1;
    tick();
    chk("ready_first_flush", Res_Ready, 1'b1);
    flush_run(0, NUM_LINES);
    chk("flush_done", {Flush_Busy, WE}, 2'b00);

    resolve("alloc_miss_taken", 32'h40, 32'h100, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10);
    chk("alloc_single_write", WE, 1'b0);
    resolve("hit_st_taken", 32'h80, 32'h200, 1'b1, 1'b1, 2'b11, 1'b1, 2'b11);
    resolve("hit_snt_nt", 32'h84, 32'h300, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
    resolve("hit_wt_nt", 32'h88, 32'h400, 1'b0, 1'b1, 2'b10, 1'b1, 2'b01);
    resolve("miss_nt", 32'h8c, 32'h500, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00);

    Flush_Req = 1'b1;
    tick();
    Flush_Req = 1'b0;
    chk("req_flush_start", {Flush_Busy, WAddr}, {1'b1, 32'h0});
    for (int i = 0; i < 5; i++) begin
      push_miss(32'h1000 + 32'(i * 4), 32'h2000 + 32'(i));
      chk("ready_while_filling", Res_Ready, (i < FIFO_DEPTH) ? 1'b1 : 1'b0);
      tick();
    end
    Res_Valid = 1'b0;
    wait_flush_end();
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", {WE, WAddr, Data, Instr_new_CB},
          {1'b1, 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i), 2'b10});
      tick();
    end
    chk("drain_end", WE, 1'b0);

    Flush_Req = 1'b1;
    tick();
    Flush_Req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_miss(32'h3000 + 32'(i * 4), 32'h4000 + 32'(i));
      tick();
    end
    Res_Valid = 1'b0;
    wait_flush_end();
    chk("head_before_reflush", {WE, WAddr}, {1'b1, 32'h3000});
    chk("ready_with_three", Res_Ready, 1'b1);
    push_miss(32'h5000, 32'h6000);
    Flush_Req = 1'b1;
    tick();
    Flush_Req = 1'b0;
    Res_Valid = 1'b0;
    chk("ready_after_clear", Res_Ready, 1'b1);
    flush_run(0, NUM_LINES);
    for (int i = 0; i < 3; i++) begin
      chk("no_stale_writes", WE, 1'b0);
      tick();
    end

    Flush_Req = 1'b1;
    tick();
    Flush_Req = 1'b0;
    flush_run(0, 60);
    chk("at_idx60", WAddr, 32'd60);
    Rst = 1'b0;
    tick();
    chk("mid_flush_reset", {WE, WAddr, Data, Instr_new_CB, Res_Ready, Flush_Busy}, '0);
    Rst = 1'b1;
    tick();
    flush_run(0, NUM_LINES);
    chk("post_reset_idle", {Flush_Busy, WE}, 2'b00);

    for (int r = 0; r < 3; r++) begin
      Flush_Req = 1'b1;
      tick();
      Flush_Req = 1'b0;
      in_fl = 1'b1;
      idx = 0;
      q.delete();
      for (int c = 0; c < NUM_LINES + 60; c++) begin
        if (in_fl) begin
          chk("rnd_flush", {Flush_Busy, WE, WAddr, Data, Instr_new_CB},
              {1'b1, 1'b1, 32'(idx), 32'h0, 2'b00});
          idx++;
          if (idx == NUM_LINES) in_fl = 1'b0;
        end else if (q.size() > 0) begin
          w = q.pop_front();
          chk("rnd_write", {Flush_Busy, WE, WAddr, Data, Instr_new_CB}, {1'b0, 1'b1, w.pc, w.tgt, w.cb});
        end else begin
          chk("rnd_idle", {Flush_Busy, WE}, 2'b00);
        end
        chk("rnd_ready", Res_Ready, (q.size() < FIFO_DEPTH) ? 1'b1 : 1'b0);
        Res_Valid = (c < NUM_LINES + 50) && ($urandom_range(0, 2) != 0);
        Res_PC = $urandom;
        Res_Target = $urandom;
        Res_Taken = 1'($urandom_range(0, 1));
        Res_Hit = 1'($urandom_range(0, 1));
        Res_OldCB = 2'($urandom_range(0, 3));
        if (Res_Valid && q.size() < FIFO_DEPTH && ref_update(Res_Hit, Res_Taken, Res_OldCB, cb))
          q.push_back('{pc: Res_PC, tgt: Res_Target, cb: cb});
        tick();
      end
      Res_Valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
